mra_frame_loader: RTL and testbench
===================================

# mra_frame_loader

AXI4 burst-read engine that sits directly upstream of the MRA routing core. On a start command it fetches one 64×64, 4-bit-per-cell map for a given frame from pseudo-DRAM: either the location map or the weight map. The map is 2048 bytes, read as 128 beats of 128 bits in a single INCR burst. Each beat is presented on a registered valid/ready stream tagged with its beat index; the core's SRAM writer consumes this stream. The block owns only the AXI read channels; write channels live elsewhere.

## Interface
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 128, AXI data width; fixed at 128 for this block
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command pulse; honoured only in IDLE
- frame_id  input  5  frame to fetch; sampled with start
- map_sel  input  1  0 = location map, 1 = weight map; sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the final beat leaves the output register
- err  output  1  sticky error flag; cleared on the next accepted start
- arid_m_inf / araddr_m_inf / arlen_m_inf / arsize_m_inf / arburst_m_inf / arvalid_m_inf  output  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AXI read address channel
- arready_m_inf  input  1  AXI read address ready
- rid_m_inf / rdata_m_inf / rresp_m_inf / rlast_m_inf / rvalid_m_inf  input  ID_WIDTH/DATA_WIDTH/2/1/1  AXI read data channel
- rready_m_inf  output  1  AXI read data ready
- out_valid  output  1  beat valid to downstream
- out_data  output  128  beat payload; cell n of the beat is out_data[4n+3:4n]
- out_idx  output  7  beat index, 0..127
- out_ready  input  1  downstream accept

## Operation
- States are IDLE, ADDR, DATA, DRAIN.
- Reset values: all outputs 0, state IDLE, beat counter 0, err 0.
- IDLE, on start:
  - latch frame_id and map_sel;
  - clear err;
  - go to ADDR.
- ADDR:
  - arvalid=1 with araddr = (map_sel ? 0x0002_0000 : 0x0001_0000) + frame_id·0x800;
  - arlen=127, arsize=3'b100, arburst=2'b01, arid=0;
  - all AR outputs are held stable until arready.
  - On arvalid&&arready, go to DATA; arvalid=0 the following cycle.
- DATA:
  - rready = !out_valid || out_ready, i.e. a single pipeline register with pass-through on accept.
  - On rvalid&&rready, load out_data=rdata, out_idx=beat counter, out_valid=1, and increment the counter.
  - On the beat with counter==127, go to DRAIN.
- DRAIN:
  - rready=0.
  - When out_valid&&out_ready, clear out_valid, pulse done, go to IDLE.
  - Only then does busy fall.
- Error conditions, each setting err (sticky); the beat is still forwarded:
  - rresp≠0;
  - rid≠0;
  - rlast=1 on a beat with counter≠127;
  - rlast=0 on beat 127.
- A burst is never aborted; exactly 128 beats are always consumed.
- start while busy is ignored, with no effect on state or latched fields.
- The counter is 7 bits and does not wrap within a transfer; it is reset to 0 on leaving IDLE.

## Timing
- start at cycle 0 gives busy=1 and arvalid=1 at cycle 1.
- With arready tied high, the handshake completes at cycle 1 and rready can first be high at cycle 2.
- Beat latency: an accepted R beat appears on out_valid the next cycle.
- Throughput: 1 beat/cycle with out_ready=1.
- Backpressure: with out_ready=0 and out_valid=1, rready=0 in the same cycle, combinationally. No beat is dropped or duplicated.
- Minimum transfer, with arready, rvalid and out_ready always 1: done pulses 131 cycles after start.
- done and busy fall happen in the same cycle; a new start is accepted in the cycle after done.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0. The DRAM side is not drained; the surrounding testbench resets DRAM alongside.

## Test plan
- Basic fetch, location map: frame_id=3, map_sel=0, all readies high.
  - araddr=0x0001_1800, arlen=127, arsize=4, arburst=1.
  - 128 beats with out_idx 0..127 in order, data matching DRAM.
  - done 131 cycles after start; err=0.
- Weight map, last frame: frame_id=31, map_sel=1.
  - araddr=0x0002_F800.
  - Last beat idx=127 equals the DRAM word at 0x0002_FFF0.
- Delays and backpressure: arready delayed 5 cycles with araddr held stable; random rvalid gaps; out_ready toggling 50%.
  - All 128 beats arrive in order with none lost.
  - rready is never high while out_valid&&!out_ready.
- Protocol errors:
  - rresp=2'b10 on beat 40: err=1 and all 128 beats still delivered.
  - Early rlast on beat 100: err=1.
  - Next start clears err.
- start while busy: a second start with frame_id=7 mid-burst is ignored; araddr is never reissued.
- Reset during DATA at beat 60: the next cycle has busy=0, out_valid=0, rready=0, arvalid=0, err=0. A fresh start then performs a full correct fetch.

Source files
------------

// File: rtl/mra_frame_loader_if.sv
// AXI4 read channels plus the beat stream toward the MRA core's SRAM writer.
// The loader is the master on both the AXI read channels and the beat stream.
interface mra_frame_loader_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ID_WIDTH-1:0]   arid_m_inf;
  logic [ADDR_WIDTH-1:0] araddr_m_inf;
  logic [7:0]            arlen_m_inf;
  logic [2:0]            arsize_m_inf;
  logic [1:0]            arburst_m_inf;
  logic                  arvalid_m_inf;
  logic                  arready_m_inf;

  logic [ID_WIDTH-1:0]   rid_m_inf;
  logic [DATA_WIDTH-1:0] rdata_m_inf;
  logic [1:0]            rresp_m_inf;
  logic                  rlast_m_inf;
  logic                  rvalid_m_inf;
  logic                  rready_m_inf;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [6:0]            out_idx;
  logic                  out_ready;

  modport master (
    output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    input  arready_m_inf,
    input  rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    output rready_m_inf,
    output out_valid, out_data, out_idx,
    input  out_ready
  );

  modport slave (
    input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    output arready_m_inf,
    output rid_m_inf, rdata_m_inf, rresp_m_inf, rlast_m_inf, rvalid_m_inf,
    input  rready_m_inf,
    input  out_valid, out_data, out_idx,
    output out_ready
  );
endinterface

// File: rtl/mra_frame_loader.sv
// Fetches one 2 KiB map (64x64 cells, 4 bits each) as a single 128-beat INCR burst
// and forwards each beat, tagged with its index, through one output register.
module mra_frame_loader #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] frame_id,
  input  logic       map_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  mra_frame_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LOC_BASE = ADDR_WIDTH'(32'h0001_0000);
  localparam logic [ADDR_WIDTH-1:0] WGT_BASE = ADDR_WIDTH'(32'h0002_0000);

  state_t                state, state_nxt;
  logic [4:0]            frame_q;
  logic                  map_q;
  logic [6:0]            cnt_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [6:0]            idx_q;
  logic                  err_q;
  logic                  done_q;

  logic                  arvalid, rready;
  logic                  start_ok, ar_fire, r_fire, o_fire;
  logic                  last_beat, beat_err;
  logic [ADDR_WIDTH-1:0] map_addr;

  assign start_ok  = (state == IDLE) && start;
  assign ar_fire   = arvalid && bus.arready_m_inf;
  assign r_fire    = bus.rvalid_m_inf && rready;
  assign o_fire    = vld_q && bus.out_ready;
  assign last_beat = (cnt_q == 7'd127);
  assign map_addr  = (map_q ? WGT_BASE : LOC_BASE) + (ADDR_WIDTH'(frame_q) << 11);

  // Any protocol irregularity is only flagged; the beat is forwarded regardless.
  assign beat_err = (bus.rresp_m_inf != 2'b00) ||
                    (bus.rid_m_inf != {ID_WIDTH{1'b0}}) ||
                    (bus.rlast_m_inf != last_beat);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start)                  state_nxt = ADDR;
      ADDR:  if (ar_fire)                state_nxt = DATA;
      DATA:  if (r_fire && last_beat)    state_nxt = DRAIN;
      DRAIN: if (o_fire)                 state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // AR fields come from latched registers, so they stay stable until arready.
  always_comb begin
    arvalid = (state == ADDR);
    rready  = (state == DATA) && (!vld_q || bus.out_ready);
    busy    = (state != IDLE);

    bus.arvalid_m_inf = arvalid;
    bus.arid_m_inf    = {ID_WIDTH{1'b0}};
    bus.araddr_m_inf  = arvalid ? map_addr : '0;
    bus.arlen_m_inf   = arvalid ? 8'd127   : 8'd0;
    bus.arsize_m_inf  = arvalid ? 3'b100   : 3'b000;
    bus.arburst_m_inf = arvalid ? 2'b01    : 2'b00;
    bus.rready_m_inf  = rready;
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign done          = done_q;
  assign err           = err_q;

  // The payload register is reset too, so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      map_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && o_fire;
      if (start_ok) begin
        frame_q <= frame_id;
        map_q   <= map_sel;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if (r_fire) begin
        data_q <= bus.rdata_m_inf;
        idx_q  <= cnt_q;
        vld_q  <= 1'b1;
        if (!last_beat) cnt_q <= cnt_q + 7'd1;
        if (beat_err)   err_q <= 1'b1;
      end else if (o_fire) begin
        vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mra_frame_loader.sv
// Randomized bench: a behavioural DRAM/consumer model drives the loader and a
// transaction-level reference checks busy/done/err, AR fields and every output beat.
module tb_mra_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] frame_id;
  logic       map_sel;
  logic       busy, done, err;

  mra_frame_loader_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

  mra_frame_loader #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_id(frame_id), .map_sel(map_sel),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pseudo-DRAM content is a pure function of the byte address.
  function automatic logic [127:0] dram_word(input logic [31:0] a);
    return {a, a ^ 32'hDEAD_BEEF, ~a, a * 32'h9E37_79B1};
  endfunction

  // Stimulus knobs.
  int ar_delay = 0, rv_pct = 100, or_pct = 100;
  int resp_err_beat = -1, early_last_beat = -1;

  // Reference model and DRAM-side state.
  bit          m_busy, m_done, m_err;
  logic [31:0] m_base;
  int          out_count, ar_count;
  logic [127:0] last_out;
  bit          ar_active, burst, saw_rst, ar_f, r_f;
  int          ar_wait, s_beat;
  logic [31:0] s_addr;

  initial begin
    bus.arready_m_inf = 1'b0; bus.rvalid_m_inf = 1'b0; bus.rid_m_inf = '0;
    bus.rdata_m_inf = '0; bus.rresp_m_inf = '0; bus.rlast_m_inf = 1'b0; bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      saw_rst = rst;
      if (rst) begin
        m_busy = 0; m_done = 0; m_err = 0; out_count = 0;
        ar_active = 0; burst = 0; s_beat = 0; ar_f = 0; r_f = 0;
      end else begin
        bit busy_n, err_n, done_n, o_f;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
        if (bus.arvalid_m_inf) begin
          check("araddr", bus.araddr_m_inf, m_base);
          check("arlen", bus.arlen_m_inf, 8'd127);
          check("arsize", bus.arsize_m_inf, 3'd4);
          check("arburst", bus.arburst_m_inf, 2'd1);
          check("arid", bus.arid_m_inf, 4'd0);
          if (!ar_active) begin ar_active = 1; ar_wait = 0; s_addr = bus.araddr_m_inf; end
        end
        if (bus.out_valid && !bus.out_ready) check("rready_under_backpressure", bus.rready_m_inf, 1'b0);
        ar_f = bus.arvalid_m_inf && bus.arready_m_inf;
        r_f  = bus.rvalid_m_inf && bus.rready_m_inf;
        o_f  = bus.out_valid && bus.out_ready;
        busy_n = m_busy; err_n = m_err; done_n = 0;
        if (r_f && (bus.rresp_m_inf != 0 || bus.rid_m_inf != 0 || bus.rlast_m_inf != (s_beat == 127)))
          err_n = 1;
        if (o_f) begin
          logic [6:0] want_idx;
          want_idx = 7'(out_count);
          check("out_idx", bus.out_idx, want_idx);
          check("out_data", bus.out_data, dram_word(m_base + 32'(out_count * 16)));
          last_out = bus.out_data;
          if (out_count == 127) begin done_n = 1; busy_n = 0; end
          out_count++;
        end
        if (start && !m_busy) begin
          busy_n = 1; err_n = 0; out_count = 0;
          m_base = (map_sel ? 32'h0002_0000 : 32'h0001_0000) + 32'(frame_id) * 32'h800;
        end
        if (ar_f) ar_count++;
        m_busy = busy_n; m_err = err_n; m_done = done_n;
      end

      @(posedge clk); #1;
      if (saw_rst) begin
        bus.arready_m_inf = 1'b0; bus.rvalid_m_inf = 1'b0; bus.out_ready = 1'b0;
      end else begin
        if (ar_f) begin ar_active = 0; burst = 1; s_beat = 0; end
        else if (ar_active) ar_wait++;
        bus.arready_m_inf = (ar_delay == 0) || (ar_active && ar_wait >= ar_delay);
        if (r_f) begin s_beat++; if (s_beat == 128) burst = 0; end
        if (!(bus.rvalid_m_inf && !r_f)) begin
          bus.rvalid_m_inf = burst && ($urandom_range(99) < rv_pct);
          bus.rdata_m_inf  = dram_word(s_addr + 32'(s_beat * 16));
          bus.rresp_m_inf  = (s_beat == resp_err_beat) ? 2'b10 : 2'b00;
          bus.rlast_m_inf  = (s_beat == 127) || (s_beat == early_last_beat);
          bus.rid_m_inf    = '0;
        end
        bus.out_ready = ($urandom_range(99) < or_pct);
      end
    end
  end

  task automatic fetch(input logic [4:0] f, input logic m, input int busy_start_at,
                       input logic exp_err, output logic [31:0] addr_seen, output int latency);
    int t0, ar0, n;
    bit got_addr;
    @(posedge clk); #1;
    start = 1'b1; frame_id = f; map_sel = m; t0 = cyc; ar0 = ar_count;
    n = 0; got_addr = 0; latency = -1; addr_seen = '0;
    while (n < 3000) begin
      @(negedge clk);
      if (bus.arvalid_m_inf && !got_addr) begin addr_seen = bus.araddr_m_inf; got_addr = 1; end
      if (done) begin latency = cyc - t0; break; end
      @(posedge clk); #1;
      n++;
      start = (n == busy_start_at);
      if (start) frame_id = 5'd7;
    end
    start = 1'b0;
    if (latency < 0) check("fetch_timeout", 1'b1, 1'b0);
    check("ar_handshakes", 32'(ar_count - ar0), 32'd1);
    check("beats_delivered", 32'(out_count), 32'd128);
    check("err_at_done", err, exp_err);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_rready", bus.rready_m_inf, 1'b0);
    check("rst_arvalid", bus.arvalid_m_inf, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_done", done, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int lat, n;
    logic [4:0] rf;
    rst = 1'b1; start = 1'b0; frame_id = '0; map_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_arvalid", bus.arvalid_m_inf, 1'b0);
    check("reset_araddr", bus.araddr_m_inf, 32'd0);
    check("reset_err", err, 1'b0);

    // Basic location-map fetch with all readies high.
    fetch(5'd3, 1'b0, -1, 1'b0, a, lat);
    check("basic_araddr", a, 32'h0001_1800);
    check("basic_latency", 32'(lat), 32'd131);

    // Weight map, last frame.
    fetch(5'd31, 1'b1, -1, 1'b0, a, lat);
    check("wgt_araddr", a, 32'h0002_F800);
    check("wgt_last_beat", last_out, dram_word(32'h0002_FFF0));

    // AR delay, random rvalid gaps, 50% output backpressure.
    ar_delay = 5; rv_pct = 60; or_pct = 50;
    fetch(5'd12, 1'b1, -1, 1'b0, a, lat);
    check("delay_araddr", a, 32'h0002_6000);

    // rresp error on beat 40, then a clean fetch clears err.
    resp_err_beat = 40;
    fetch(5'd9, 1'b0, -1, 1'b1, a, lat);
    resp_err_beat = -1;
    fetch(5'd9, 1'b0, -1, 1'b0, a, lat);

    // Early rlast on beat 100.
    early_last_beat = 100;
    fetch(5'd20, 1'b0, -1, 1'b1, a, lat);
    early_last_beat = -1;

    // A start with frame 7 mid-burst must be ignored.
    fetch(5'd5, 1'b0, 50, 1'b0, a, lat);
    check("ignored_start_araddr", a, 32'h0001_2800);

    // Reset during DATA at beat 60, with err already set by an earlier beat.
    ar_delay = 0; rv_pct = 100; or_pct = 100; resp_err_beat = 10;
    @(posedge clk); #1; start = 1'b1; frame_id = 5'd14; map_sel = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (out_count < 60 && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) check("reset_wait_timeout", 1'b1, 1'b0);
    pulse_reset();
    resp_err_beat = -1;
    fetch(5'd14, 1'b1, -1, 1'b0, a, lat);
    check("post_reset_araddr", a, 32'h0002_7000);

    // Randomized fetches.
    for (int i = 0; i < 4; i++) begin
      ar_delay = $urandom_range(3); rv_pct = 40 + $urandom_range(60); or_pct = 30 + $urandom_range(70);
      rf = 5'($urandom);
      fetch(rf, 1'($urandom), -1, 1'b0, a, lat);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
